// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable-framing UART receiver.
// Data width, parity and stop bits are parameters; reports parity/framing/break/overrun.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ack,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_EXP   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_BREAK_WAIT
    } state_t;

    logic                 meta_q;
    logic                 sync_q;

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [DATA_BITS-1:0] shadow_q,   shadow_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 brk_acc_q,  brk_acc_d;

    logic                 dv_q,       dv_d;
    logic [DATA_BITS-1:0] byte_q,     byte_d;
    logic                 perr_q,     perr_d;
    logic                 ferr_q,     ferr_d;
    logic                 brk_q,      brk_d;
    logic                 pend_q,     pend_d;
    logic                 ovr_q,      ovr_d;

    logic                 perr_now;
    logic                 brk_now;

    // Parity check over the completed shadow byte and the sampled parity bit.
    assign perr_now = (PARITY != 0) &&
                      (((^shadow_q) ^ par_bit_q) != PAR_EXP);

    // A break is an all-zero frame up to and including the first stop sample.
    assign brk_now = (shadow_q == '0) &&
                     ((PARITY == 0) || !par_bit_q) &&
                     !sync_q;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_Rx_Serial;
            sync_q <= meta_q;
        end
    end

    // Next-state logic: frame sequencing, sampling and flag generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        par_bit_d  = par_bit_q;
        ferr_acc_d = ferr_acc_q;
        brk_acc_d  = brk_acc_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!sync_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!sync_q) begin
                        state_d    = S_DATA;
                        idx_d      = '0;
                        ferr_acc_d = 1'b0;
                        brk_acc_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    // LSB arrives first; after DATA_BITS shifts it sits in bit 0.
                    shadow_d = {sync_q, shadow_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_BIT) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    par_bit_d = sync_q;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (idx_q == LAST_STOP) begin
                        dv_d    = 1'b1;
                        byte_d  = shadow_q;
                        perr_d  = perr_now;
                        ferr_d  = ferr_acc_q | ~sync_q;
                        brk_d   = (idx_q == '0) ? brk_now : brk_acc_q;
                        idx_d   = '0;
                        state_d = S_CLEANUP;
                    end else begin
                        ferr_acc_d = ferr_acc_q | ~sync_q;
                        if (idx_q == '0) begin
                            brk_acc_d = brk_now;
                        end
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CLEANUP: begin
                cnt_d   = '0;
                state_d = brk_q ? S_BREAK_WAIT : S_IDLE;
            end

            S_BREAK_WAIT: begin
                cnt_d = '0;
                if (sync_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Overrun tracking: an ack coinciding with a new frame retires the old one.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (dv_q) begin
            pend_d = 1'b1;
            if (pend_q && !i_Rx_Ack) begin
                ovr_d = 1'b1;
            end else if (i_Rx_Ack) begin
                ovr_d = 1'b0;
            end
        end else if (i_Rx_Ack) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            brk_acc_q  <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            par_bit_q  <= par_bit_d;
            ferr_acc_q <= ferr_acc_d;
            brk_acc_q  <= brk_acc_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Break      = brk_q;
    assign o_Overrun    = ovr_q;

endmodule
